// File: rtl/lsu_axi_bridge.sv
// LSU-to-AXI4-Lite bridge: one single-beat read or write in flight,
// completed by a one-cycle response pulse back to the load/store unit.
module lsu_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  reqValid,
  input  logic                  req_wen,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_wmask,
  output logic                  respValid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  busy,
  output logic [ADDR_W-1:0]     awaddr,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [ADDR_W-1:0]     araddr,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    DONE
  } state_t;

  state_t                state;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   wmask_q;
  logic                  aw_done;
  logic                  w_done;

  logic aw_hs;
  logic w_hs;
  logic aw_fin;
  logic w_fin;

  // A channel counts as finished if it completed earlier or completes now.
  always_comb begin
    aw_hs  = awvalid & awready;
    w_hs   = wvalid & wready;
    aw_fin = aw_done | aw_hs;
    w_fin  = w_done | w_hs;
  end

  assign awaddr = addr_q;
  assign araddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wmask_q;

  logic unused_bits;
  assign unused_bits = ^{req_addr[1:0], rresp[0], bresp[0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      respValid  <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      arvalid    <= 1'b0;
      rready     <= 1'b0;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (reqValid) begin
            addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            busy    <= 1'b1;
            if (req_wen) begin
              state   <= WR_REQ;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              state   <= RD_ADDR;
              arvalid <= 1'b1;
            end
          end
        end
        RD_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready     <= 1'b0;
            resp_rdata <= rdata;
            resp_err   <= rresp[1];
            respValid  <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
        WR_REQ: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
            state   <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= bresp[1];
            respValid  <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end
        end
        DONE: begin
          respValid <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
